aip_mem_bridge: RTL and testbench
=================================

# aip_mem_bridge

Bridges the picorv32 native memory bus to one AIP-protocol IP core (conf/read/write/start/data/int). It sits between the SoC address decode, which supplies `sel`, and the IP core, such as the dummy core. It turns CPU loads and stores inside a 16-byte register window into single-cycle AIP strobes. It also latches the core's interrupt lines into a maskable CPU interrupt.

## Interface
Parameters:
- `DATA_W`, 32: CPU and AIP data width.
- `CONF_W`, 5: AIP config bus width.
- `INT_W`, 16: AIP interrupt vector width.
- `RD_LATENCY`, 1: cycles from `aip_read` high to `aip_data_out` valid (1..7).

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `cpu_mem_valid`, in, 1: picorv32 request valid.
- `cpu_sel`, in, 1: address decode hit for this bridge's window.
- `cpu_mem_addr`, in, 32: byte address; only [3:2] decoded.
- `cpu_mem_wdata`, in, DATA_W: store data.
- `cpu_mem_wstrb`, in, 4: nonzero means store; any nonzero value is treated as a full-word write.
- `cpu_mem_rdata`, out, DATA_W: load data, valid while `cpu_mem_ready`=1, else 0.
- `cpu_mem_ready`, out, 1: one-cycle completion pulse.
- `cpu_irq`, out, 1: `irq_en` & |`int_pend`.
- `aip_data_in`, out, DATA_W: data to the core.
- `aip_data_out`, in, DATA_W: data from the core.
- `aip_conf`, out, CONF_W: config register.
- `aip_read`, `aip_write`, `aip_start`, out, 1 each: one-cycle strobes.
- `aip_int`, in, INT_W: core interrupt lines (level).

## Operation
Register window, selected by `cpu_mem_addr[3:2]`:
- 0x0 DATA
  - Store: `aip_data_in`←wdata, pulse `aip_write`.
  - Load: pulse `aip_read`, return `aip_data_out` sampled RD_LATENCY cycles later.
- 0x4 CONF: R/W; store writes wdata[CONF_W-1:0]; load returns it zero-extended.
- 0x8 CTRL
  - Store: bit0=1 pulses `aip_start`; bit1 → `irq_en`.
  - Load: {30'b0, irq_en, 1'b0}.
- 0xC INT
  - Load: `int_pend` zero-extended.
  - Store: write-1-to-clear `int_pend`.

Interrupt latch:
- `int_pend[i]` sets on a rising edge of `aip_int[i]`, detected against a registered copy.
- On a same-cycle set and W1C clear of the same bit, set wins.

FSM states:
- IDLE: on `cpu_mem_valid`&`cpu_sel` register the offset, store flag and wdata, then go to ISSUE. Otherwise stay.
- ISSUE: assert the strobe for the access (at most one strobe high).
  - DATA load → WAIT, with counter ← RD_LATENCY-1.
  - All other accesses → DONE.
- WAIT: decrement the counter. At 0, capture `aip_data_out` into the read register and go to DONE.
- DONE: `cpu_mem_ready`=1 with the read register on `cpu_mem_rdata`; go to IDLE.

Side effects:
- CONF, CTRL, and INT-W1C side effects commit at the ISSUE edge.
- Once accepted, a request runs to completion even if `cpu_mem_valid` drops.
- `cpu_sel`=0 is never acknowledged.

## Timing
- Reset values: `cpu_mem_ready`, `cpu_mem_rdata`, strobes, `aip_data_in`, `aip_conf`, `irq_en`, `int_pend`, `cpu_irq` = 0. FSM = IDLE.
- Request accepted at edge E0. Strobes are high in cycle E0+1.
- Ready latency:
  - `cpu_mem_ready` high in cycle E0+2 for stores and non-DATA loads.
  - E0+2+RD_LATENCY for DATA loads.
- `aip_data_in` holds its value until the next DATA store.
- `aip_conf` changes only on a CONF store.
- A new request is accepted no earlier than the cycle after DONE; back-to-back throughput is 3 cycles per access minimum.
- `cpu_irq` rises 2 cycles after an `aip_int` rising edge when `irq_en`=1: 1 cycle for edge registration, 1 for the pending bit.
- `resetn` low mid-transaction: immediate return to IDLE, strobes drop asynchronously, no ready is issued. The CPU is reset alongside.

## Structure
- Package `aip_bridge_pkg`:
  - Offset constants `AIP_OFF_DATA`, `AIP_OFF_CONF`, `AIP_OFF_CTRL`, `AIP_OFF_INT`.
  - CTRL bit indices.
  - FSM state encoding IDLE/ISSUE/WAIT/DONE.
- Sub-module `aip_int_latch`, parameterised by INT_W: edge detect, sticky pending, W1C with set priority.
- The top holds the FSM, registers and read mux.

## Test plan
- Reset: hold `resetn`=0 with `aip_int`=16'hFFFF → all outputs 0. Release → `int_pend` stays 0 until a new rising edge.
- Store 0xDEADBEEF to DATA → `aip_write` high exactly 1 cycle at E0+1 with `aip_data_in`=0xDEADBEEF; ready at E0+2.
- DATA load with RD_LATENCY=1 and the core returning 0x12345678 one cycle after `aip_read` → rdata=0x12345678, ready at E0+3. Repeat with RD_LATENCY=3 → ready at E0+5.
- CONF and CTRL:
  - Store 0x1F to CONF → `aip_conf`=5'h1F; load returns 0x1F.
  - Store 0x3 to CTRL → one `aip_start` pulse, `irq_en`=1; load returns 0x2.
- Interrupts:
  - Raise `aip_int[0]` with `irq_en`=1 → `cpu_irq` 2 cycles later.
  - W1C 0x1 → `cpu_irq` clears.
  - W1C in the same cycle as a new edge on bit 0 → bit stays set.
- Assert `resetn`=0 in the WAIT state → no ready is issued; after release an INT load returns 0 and the FSM accepts new requests normally.

Source files
------------

// File: rtl/aip_bridge_pkg.sv
// Shared definitions for the picorv32-to-AIP memory bridge.
//   - Register window offsets (word index, cpu_mem_addr[3:2])
//   - CTRL register bit positions
//   - Bridge FSM state encoding
package aip_bridge_pkg;

    // Word offsets inside the 16-byte register window.
    localparam logic [1:0] AIP_OFF_DATA = 2'd0;
    localparam logic [1:0] AIP_OFF_CONF = 2'd1;
    localparam logic [1:0] AIP_OFF_CTRL = 2'd2;
    localparam logic [1:0] AIP_OFF_INT  = 2'd3;

    // CTRL register bits.
    localparam int unsigned AIP_CTRL_START  = 0;
    localparam int unsigned AIP_CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } aip_state_e;

endpackage

// File: rtl/aip_int_latch.sv
// Interrupt latch for the AIP bridge.
// Detects rising edges on the core's level interrupt lines and holds them in a
// sticky pending vector that the CPU clears by writing ones.
//
// Ports:
//   clk          clock, rising edge
//   resetn       asynchronous active-low reset
//   aip_int_i    core interrupt lines (level)
//   clr_en_i     one-cycle write-1-to-clear enable
//   clr_mask_i   bits to clear when clr_en_i is high
//   int_pend_o   sticky pending bits
module aip_int_latch #(
    parameter int unsigned INT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [INT_W-1:0] aip_int_i,
    input  logic             clr_en_i,
    input  logic [INT_W-1:0] clr_mask_i,
    output logic [INT_W-1:0] int_pend_o
);

    logic [INT_W-1:0] in_q, in_d;
    logic [INT_W-1:0] prev_q, prev_d;
    logic [INT_W-1:0] pend_q, pend_d;
    logic [INT_W-1:0] rise;

    always_comb begin
        in_d   = aip_int_i;
        prev_d = in_q;
        rise   = in_q & ~prev_q;
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d = pend_d & ~clr_mask_i;
        end
        // A new edge in the same cycle as a clear must not be lost.
        pend_d = pend_d | rise;
    end

    // The edge history resets to all-ones so lines already high when reset is
    // released do not count as fresh edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_q   <= '1;
            prev_q <= '1;
            pend_q <= '0;
        end else begin
            in_q   <= in_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign int_pend_o = pend_q;

endmodule

// File: rtl/aip_mem_bridge.sv
// Bridge from the picorv32 native memory bus to one AIP-protocol IP core.
// CPU accesses to a 16-byte window become single-cycle AIP strobes; the core's
// interrupt lines are latched into a maskable CPU interrupt.
//
// Ports:
//   clk, resetn          clock (rising edge), async active-low reset
//   cpu_mem_valid        picorv32 request valid
//   cpu_sel              address decode hit for this window
//   cpu_mem_addr         byte address, only [3:2] decoded
//   cpu_mem_wdata        store data
//   cpu_mem_wstrb        nonzero = store (always treated as full word)
//   cpu_mem_rdata        load data, zero unless cpu_mem_ready
//   cpu_mem_ready        one-cycle completion pulse
//   cpu_irq              irq_en & any pending interrupt
//   aip_data_in          data to the core, held until the next DATA store
//   aip_data_out         data from the core
//   aip_conf             config register
//   aip_read/write/start one-cycle strobes to the core
//   aip_int              core interrupt lines (level)
module aip_mem_bridge
    import aip_bridge_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CONF_W     = 5,
    parameter int unsigned INT_W      = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_mem_valid,
    input  logic              cpu_sel,
    input  logic [31:0]       cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_wdata,
    input  logic [3:0]        cpu_mem_wstrb,
    output logic [DATA_W-1:0] cpu_mem_rdata,
    output logic              cpu_mem_ready,
    output logic              cpu_irq,
    output logic [DATA_W-1:0] aip_data_in,
    input  logic [DATA_W-1:0] aip_data_out,
    output logic [CONF_W-1:0] aip_conf,
    output logic              aip_read,
    output logic              aip_write,
    output logic              aip_start,
    input  logic [INT_W-1:0]  aip_int
);

    // Counter preload so WAIT lasts exactly RD_LATENCY cycles.
    localparam logic [2:0] CntInit = 3'(RD_LATENCY - 1);

    aip_state_e        state_q, state_d;
    logic [1:0]        off_q, off_d;
    logic              store_q, store_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic              irq_en_q, irq_en_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              start_q, start_d;

    logic              accept;
    logic              cpu_store;
    logic              clr_en;
    logic [INT_W-1:0]  int_pend;
    logic [DATA_W-1:0] rd_mux;

    // Only [3:2] of the address is decoded; only some wdata bits reach registers.
    logic              unused_addr;
    logic              unused_wdata;
    assign unused_addr  = ^{cpu_mem_addr[31:4], cpu_mem_addr[1:0]};
    assign unused_wdata = ^wdata_q;

    aip_int_latch #(
        .INT_W (INT_W)
    ) u_int_latch (
        .clk        (clk),
        .resetn     (resetn),
        .aip_int_i  (aip_int),
        .clr_en_i   (clr_en),
        .clr_mask_i (wdata_q[INT_W-1:0]),
        .int_pend_o (int_pend)
    );

    assign accept    = (state_q == StIdle) & cpu_mem_valid & cpu_sel;
    assign cpu_store = |cpu_mem_wstrb;
    assign clr_en    = (state_q == StIssue) & store_q & (off_q == AIP_OFF_INT);

    // Read mux for the non-DATA registers, sampled at the ISSUE edge.
    always_comb begin
        rd_mux = '0;
        unique case (off_q)
            AIP_OFF_CONF: rd_mux[CONF_W-1:0]     = conf_q;
            AIP_OFF_CTRL: rd_mux[AIP_CTRL_IRQ_EN] = irq_en_q;
            AIP_OFF_INT:  rd_mux[INT_W-1:0]      = int_pend;
            default:      rd_mux                 = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        store_d   = store_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        data_in_d = data_in_q;
        conf_d    = conf_q;
        irq_en_d  = irq_en_q;
        read_d    = 1'b0;
        write_d   = 1'b0;
        start_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    off_d   = cpu_mem_addr[3:2];
                    store_d = cpu_store;
                    wdata_d = cpu_mem_wdata;
                    rdata_d = '0;
                    state_d = StIssue;
                    // Strobes are registered here so they are high during ISSUE.
                    unique case (cpu_mem_addr[3:2])
                        AIP_OFF_DATA: begin
                            if (cpu_store) begin
                                write_d   = 1'b1;
                                data_in_d = cpu_mem_wdata;
                            end else begin
                                read_d = 1'b1;
                            end
                        end
                        AIP_OFF_CTRL: start_d = cpu_store & cpu_mem_wdata[AIP_CTRL_START];
                        default:      start_d = 1'b0;
                    endcase
                end
            end
            StIssue: begin
                if (store_q) begin
                    unique case (off_q)
                        AIP_OFF_CONF: conf_d   = wdata_q[CONF_W-1:0];
                        AIP_OFF_CTRL: irq_en_d = wdata_q[AIP_CTRL_IRQ_EN];
                        default:      conf_d   = conf_q;
                    endcase
                end else begin
                    rdata_d = rd_mux;
                end
                if (!store_q && (off_q == AIP_OFF_DATA)) begin
                    cnt_d   = CntInit;
                    state_d = StWait;
                end else begin
                    state_d = StDone;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = aip_data_out;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            off_q     <= AIP_OFF_DATA;
            store_q   <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= 3'd0;
            rdata_q   <= '0;
            data_in_q <= '0;
            conf_q    <= '0;
            irq_en_q  <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            store_q   <= store_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            data_in_q <= data_in_d;
            conf_q    <= conf_d;
            irq_en_q  <= irq_en_d;
            read_q    <= read_d;
            write_q   <= write_d;
            start_q   <= start_d;
        end
    end

    assign cpu_mem_ready = (state_q == StDone);
    assign cpu_mem_rdata = cpu_mem_ready ? rdata_q : '0;
    assign cpu_irq       = irq_en_q & (|int_pend);
    assign aip_data_in   = data_in_q;
    assign aip_conf      = conf_q;
    assign aip_read      = read_q;
    assign aip_write     = write_q;
    assign aip_start     = start_q;

endmodule

// File: tb/tb_aip_mem_bridge.sv
// Bench for aip_mem_bridge: a transaction-level model tracks what every output
// must be each cycle for the RD_LATENCY=1 instance; a second RD_LATENCY=3
// instance is checked with directed literal expectations.
module tb_aip_mem_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        cpu_mem_valid = 1'b0;
    logic        sel1 = 1'b0;
    logic        sel3 = 1'b0;
    logic [31:0] cpu_mem_addr = '0;
    logic [31:0] cpu_mem_wdata = '0;
    logic [3:0]  cpu_mem_wstrb = '0;
    logic [31:0] aip_data_out = '0;
    logic [15:0] aip_int = '0;

    logic [31:0] rdata1, rdata3, data_in1, data_in3;
    logic        ready1, ready3, irq1, irq3;
    logic [4:0]  conf1, conf3;
    logic        read1, read3, write1, write3, start1, start3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    aip_mem_bridge #(
        .DATA_W(32), .CONF_W(5), .INT_W(16), .RD_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .resetn(resetn), .cpu_mem_valid(cpu_mem_valid), .cpu_sel(sel1),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_rdata(rdata1), .cpu_mem_ready(ready1),
        .cpu_irq(irq1), .aip_data_in(data_in1), .aip_data_out(aip_data_out),
        .aip_conf(conf1), .aip_read(read1), .aip_write(write1), .aip_start(start1),
        .aip_int(aip_int)
    );

    aip_mem_bridge #(
        .DATA_W(32), .CONF_W(5), .INT_W(16), .RD_LATENCY(3)
    ) u_dut3 (
        .clk(clk), .resetn(resetn), .cpu_mem_valid(cpu_mem_valid), .cpu_sel(sel3),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_rdata(rdata3), .cpu_mem_ready(ready3),
        .cpu_irq(irq3), .aip_data_in(data_in3), .aip_data_out(aip_data_out),
        .aip_conf(conf3), .aip_read(read3), .aip_write(write3), .aip_start(start3),
        .aip_int(aip_int)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Core stand-in: drives core_val exactly core_sel+1 cycles after a read
    // strobe, junk otherwise, so a capture on the wrong cycle is visible.
    logic [7:0]  rd_hist = '0;
    logic        rd_now = 1'b0;
    logic [2:0]  core_sel = 3'd0;
    logic [31:0] core_val = 32'h1234_5678;
    logic [15:0] junk = '0;

    initial forever begin
        @(negedge clk);
        rd_now = read1 | read3;
    end

    initial forever begin
        @(posedge clk);
        rd_hist = {rd_hist[6:0], rd_now};
        #1;
        if (rd_hist[core_sel]) aip_data_out = core_val;
        else aip_data_out = {16'hBAD0, junk};
        junk = junk + 16'd1;
    end

    // Transaction-level model of the RD_LATENCY=1 instance.
    bit          m_busy;
    int          m_ph, m_rdy;
    logic [1:0]  m_off;
    bit          m_st;
    logic [31:0] m_wd, m_rd, m_data_in;
    logic [4:0]  m_conf;
    logic        m_irq_en;
    logic [15:0] m_pend, m_clr, m_rise, h1, h2;

    task automatic model_reset();
        m_busy = 0; m_ph = 0; m_rdy = 0; m_off = '0; m_st = 0; m_wd = '0; m_rd = '0;
        m_data_in = '0; m_conf = '0; m_irq_en = 1'b0; m_pend = '0;
        h1 = '1; h2 = '1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                model_reset();
            end else begin
                m_clr  = '0;
                m_rise = h1 & ~h2;
                if (m_busy) begin
                    if (m_ph == m_rdy) begin
                        m_busy = 0;
                    end else begin
                        if (m_ph == 1) begin
                            if (m_st) begin
                                if (m_off == 2'd1) m_conf = m_wd[4:0];
                                else if (m_off == 2'd2) m_irq_en = m_wd[1];
                                else if (m_off == 2'd3) m_clr = m_wd[15:0];
                            end else begin
                                if (m_off == 2'd1) m_rd = {27'd0, m_conf};
                                else if (m_off == 2'd2) m_rd = {30'd0, m_irq_en, 1'b0};
                                else if (m_off == 2'd3) m_rd = {16'd0, m_pend};
                            end
                        end
                        m_ph = m_ph + 1;
                        if (!m_st && m_off == 2'd0 && m_ph == m_rdy) m_rd = aip_data_out;
                    end
                end else if (cpu_mem_valid && sel1) begin
                    m_busy = 1;
                    m_ph   = 1;
                    m_off  = cpu_mem_addr[3:2];
                    m_st   = (cpu_mem_wstrb != 4'd0);
                    m_wd   = cpu_mem_wdata;
                    m_rd   = '0;
                    m_rdy  = (!m_st && m_off == 2'd0) ? 3 : 2;
                    if (m_st && m_off == 2'd0) m_data_in = cpu_mem_wdata;
                end
                m_pend = (m_pend & ~m_clr) | m_rise;
                h2 = h1;
                h1 = aip_int;
            end
        end
    end

    // Per-cycle comparison of every dut1 output against the model.
    initial forever begin
        logic e_ready;
        logic e_issue;
        @(negedge clk);
        e_ready = m_busy && (m_ph == m_rdy);
        e_issue = m_busy && (m_ph == 1);
        chk("ready", ready1, e_ready);
        chk("rdata", rdata1, e_ready ? m_rd : 32'd0);
        chk("read", read1, e_issue && !m_st && m_off == 2'd0);
        chk("write", write1, e_issue && m_st && m_off == 2'd0);
        chk("start", start1, e_issue && m_st && m_off == 2'd2 && m_wd[0]);
        chk("data_in", data_in1, m_data_in);
        chk("conf", conf1, m_conf);
        chk("irq", irq1, m_irq_en && (m_pend != 16'd0));
    end

    task automatic access(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input bit use3, input logic [15:0] intv,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = addr;
        cpu_mem_wdata = wd;
        cpu_mem_wstrb = ws;
        aip_int       = intv;
        if (use3) sel3 = 1'b1;
        else sel1 = 1'b1;
        lat = 0;
        rd  = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if ((use3 ? ready3 : ready1) === 1'b1) begin
                lat = n;
                rd  = use3 ? rdata3 : rdata1;
                break;
            end
        end
        cpu_mem_valid = 1'b0;
        sel1 = 1'b0;
        sel3 = 1'b0;
        cpu_mem_wstrb = '0;
        if (lat == 0) chk("access_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat;
        int seen;

        // Reset with all interrupt lines high.
        #1;
        resetn  = 1'b0;
        aip_int = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("rst_conf", conf1, 32'd0);
        chk("rst_irq", irq1, 32'd0);
        chk("rst_ready", ready1, 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        access(32'hC, 32'd0, 4'h0, 0, aip_int, rd, lat);
        chk("int_after_rst", rd, 32'd0);
        chk("int_after_rst_lat", lat, 32'd2);
        aip_int = 16'h0000;

        // DATA store.
        access(32'h0, 32'hDEAD_BEEF, 4'hF, 0, aip_int, rd, lat);
        chk("dstore_lat", lat, 32'd2);
        chk("dstore_data_in", data_in1, 32'hDEAD_BEEF);

        // DATA loads at latency 1 and 3.
        core_sel = 3'd0;
        access(32'h0, 32'd0, 4'h0, 0, aip_int, rd, lat);
        chk("dload1_rdata", rd, 32'h1234_5678);
        chk("dload1_lat", lat, 32'd3);
        core_sel = 3'd2;
        access(32'h0, 32'd0, 4'h0, 1, aip_int, rd, lat);
        chk("dload3_rdata", rd, 32'h1234_5678);
        chk("dload3_lat", lat, 32'd5);
        core_sel = 3'd0;
        chk("data_in_held", data_in1, 32'hDEAD_BEEF);

        // CONF.
        access(32'h4, 32'h0000_001F, 4'hF, 0, aip_int, rd, lat);
        chk("conf_1f", conf1, 32'h1F);
        access(32'h4, 32'd0, 4'h0, 0, aip_int, rd, lat);
        chk("conf_load_1f", rd, 32'h1F);
        access(32'h4, 32'hABCD_EF2A, 4'h1, 0, aip_int, rd, lat);
        chk("conf_trunc", conf1, 32'h0A);
        access(32'h4, 32'd0, 4'h0, 0, aip_int, rd, lat);
        chk("conf_load_0a", rd, 32'h0A);

        // CTRL.
        access(32'h8, 32'h3, 4'hF, 0, aip_int, rd, lat);
        chk("ctrl_store_lat", lat, 32'd2);
        access(32'h8, 32'd0, 4'h0, 0, aip_int, rd, lat);
        chk("ctrl_load", rd, 32'h2);

        // cpu_sel low is never acknowledged.
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h4;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready1 === 1'b1) seen++;
        end
        cpu_mem_valid = 1'b0;
        chk("nosel_ready", seen, 32'd0);

        // Interrupt rises two cycles after the line.
        @(negedge clk);
        aip_int = 16'h0001;
        @(posedge clk);
        #1;
        chk("irq_after_1", irq1, 32'd0);
        @(posedge clk);
        #1;
        chk("irq_after_2", irq1, 32'd1);

        // W1C clears it.
        access(32'hC, 32'h1, 4'hF, 0, aip_int, rd, lat);
        chk("irq_w1c", irq1, 32'd0);
        access(32'hC, 32'd0, 4'h0, 0, aip_int, rd, lat);
        chk("int_after_w1c", rd, 32'd0);

        // W1C coinciding with a fresh edge: set wins.
        @(negedge clk);
        aip_int = 16'h0000;
        repeat (3) @(negedge clk);
        access(32'hC, 32'h1, 4'hF, 0, 16'h0001, rd, lat);
        access(32'hC, 32'd0, 4'h0, 0, aip_int, rd, lat);
        chk("set_wins", rd, 32'h1);
        chk("set_wins_irq", irq1, 32'd1);

        // Reset during WAIT of the latency-3 instance.
        core_sel = 3'd2;
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        sel3          = 1'b1;
        cpu_mem_addr  = 32'h0;
        cpu_mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        cpu_mem_valid = 1'b0;
        sel3          = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_wait_read3", read3, 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready3 === 1'b1) seen++;
        end
        resetn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (ready3 === 1'b1) seen++;
        end
        chk("rst_wait_no_ready", seen, 32'd0);
        access(32'hC, 32'd0, 4'h0, 0, aip_int, rd, lat);
        chk("post_rst_int", rd, 32'd0);
        access(32'h4, 32'd0, 4'h0, 1, aip_int, rd, lat);
        chk("post_rst_dut3_lat", lat, 32'd2);
        chk("post_rst_dut3_conf", rd, 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
